spwm_sequencer: RTL and testbench

- Single-channel SPWM controller for the H-bridge output pair.
- Runs one 8-bit carrier counter and schedules the duty level per carrier period through a symmetric quarter-wave table.
- Steers pulses to outa on the positive half-cycle and to outb on the negative half-cycle.
- Inserts a rising-edge dead time on each output and provides run/stop sequencing so a stop never truncates a half-cycle.

---
 rtl/spwm_pkg.sv | 39 +++
 rtl/spwm_sequencer_if.sv | 22 ++
 rtl/spwm_deadtime_gate.sv | 31 +++
 rtl/spwm_sequencer.sv | 118 +++++++++++
 tb/tb_spwm_sequencer.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/spwm_pkg.sv
// Shared constants, state encoding and duty-table helpers for the SPWM sequencer.
package spwm_pkg;

  localparam int CNT_W            = 8;
  localparam int N_STEPS          = 5;
  localparam int DEADTIME_DEFAULT = 4;
  localparam int IDX_W            = 3;
  localparam int POS_W            = 4;
  localparam int DUTY_W           = 8;

  localparam logic [POS_W-1:0] POS_HALF = POS_W'(N_STEPS);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(2 * N_STEPS - 1);

  // Quarter-wave duty table; mirrored in time to build the half-cycle.
  localparam logic [DUTY_W-1:0] DUTY_TABLE [N_STEPS] = '{
    8'd23, 8'd88, 8'd164, 8'd221, 8'd251
  };

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPING
  } state_t;

  // Fold the half-cycle position onto the quarter-wave table index.
  function automatic logic [IDX_W-1:0] pos_to_idx(input logic [POS_W-1:0] pos);
    logic [POS_W-1:0] mirror;
    mirror = POS_LAST - pos;
    if (pos < POS_HALF) return pos[IDX_W-1:0];
    return mirror[IDX_W-1:0];
  endfunction

  // Table lookup that yields zero for an index outside the table.
  function automatic logic [DUTY_W-1:0] duty_lookup(input logic [IDX_W-1:0] idx);
    if (idx < IDX_W'(N_STEPS)) return DUTY_TABLE[idx];
    return '0;
  endfunction

endpackage

// File: rtl/spwm_sequencer_if.sv
// Run request and gate-drive/status bundle of the SPWM sequencer.
interface spwm_sequencer_if;
  import spwm_pkg::*;

  logic             en;
  logic             outa;
  logic             outb;
  logic             half;
  logic [IDX_W-1:0] idx;
  logic             period_strobe;
  logic             busy;

  modport master (
    output en,
    input  outa, outb, half, idx, period_strobe, busy
  );

  modport slave (
    input  en,
    output outa, outb, half, idx, period_strobe, busy
  );
endinterface

// File: rtl/spwm_deadtime_gate.sv
// Rising-edge dead-time gate: output follows raw after DEADTIME+1 clocks high,
// drops one clock after raw falls.
module spwm_deadtime_gate #(
  parameter int DEADTIME = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic gated
);

  localparam int              DT_W   = 8;
  localparam logic [DT_W-1:0] DT_MAX = DT_W'(DEADTIME);

  logic [DT_W-1:0] dt_cnt;

  // Saturating high-time counter; the output uses the pre-increment count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dt_cnt <= '0;
      gated  <= 1'b0;
    end else begin
      gated <= raw && (dt_cnt == DT_MAX);
      if (!raw)
        dt_cnt <= '0;
      else if (dt_cnt != DT_MAX)
        dt_cnt <= dt_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spwm_sequencer.sv
// Single-channel SPWM sequencer: carrier counter, quarter-wave duty schedule,
// half-cycle steering to outa/outb and run/stop sequencing on half boundaries.
module spwm_sequencer
  import spwm_pkg::*;
#(
  parameter int DEADTIME = DEADTIME_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  spwm_sequencer_if.slave  bus
);

  state_t              state, state_next;
  logic [CNT_W-1:0]    cnt;
  logic [POS_W-1:0]    pos;
  logic [POS_W-1:0]    pos_next;
  logic [IDX_W-1:0]    idx_q;
  logic [IDX_W-1:0]    idx_next;
  logic [DUTY_W-1:0]   duty_q;
  logic                half_q;
  logic                strobe_q;
  logic                busy_q;
  logic                cnt_max;
  logic                half_end;
  logic                raw;
  logic                out_a;
  logic                out_b;

  assign cnt_max  = &cnt;
  assign half_end = cnt_max && (pos == POS_LAST);
  assign pos_next = (pos == POS_LAST) ? '0 : pos + 1'b1;
  assign idx_next = pos_to_idx(pos_next);
  assign raw      = (state != IDLE) && (cnt < duty_q);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: a stop only takes effect at the end of a half-cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (bus.en) state_next = RUN;
      RUN:      if (!bus.en) state_next = STOPPING;
      STOPPING: begin
        if (bus.en)        state_next = RUN;
        else if (half_end) state_next = IDLE;
      end
      default:  state_next = IDLE;
    endcase
  end

  // Carrier, step position, half flag and shadowed duty level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      pos    <= '0;
      half_q <= 1'b0;
      idx_q  <= '0;
      duty_q <= '0;
    end else if (state == IDLE) begin
      cnt    <= '0;
      pos    <= '0;
      half_q <= 1'b0;
      idx_q  <= '0;
      if (state_next == RUN) duty_q <= duty_lookup('0);
    end else if (state_next == IDLE) begin
      cnt    <= '0;
      pos    <= '0;
      half_q <= 1'b0;
      idx_q  <= '0;
      duty_q <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (cnt_max) begin
        pos    <= pos_next;
        idx_q  <= idx_next;
        duty_q <= duty_lookup(idx_next);
        if (pos == POS_LAST) half_q <= ~half_q;
      end
    end
  end

  // Period strobe and busy flag, both registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      strobe_q <= (state != IDLE) && cnt_max;
      busy_q   <= (state_next != IDLE);
    end
  end

  spwm_deadtime_gate #(.DEADTIME(DEADTIME)) u_gate_a (
    .clk   (clk),
    .rst   (rst),
    .raw   (raw & ~half_q),
    .gated (out_a)
  );

  spwm_deadtime_gate #(.DEADTIME(DEADTIME)) u_gate_b (
    .clk   (clk),
    .rst   (rst),
    .raw   (raw & half_q),
    .gated (out_b)
  );

  assign bus.outa          = out_a;
  assign bus.outb          = out_b;
  assign bus.half          = half_q;
  assign bus.idx           = idx_q;
  assign bus.period_strobe = strobe_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_spwm_sequencer.sv
// Scoreboard bench for spwm_sequencer: expected per-period pulse counts are
// queued from a plain arithmetic model and compared on each period strobe.
module tb_spwm_sequencer;
  import spwm_pkg::*;

  localparam int DT        = 4;
  localparam int PERIOD    = 256;
  localparam int HALF_CLKS = 2560;
  localparam int REF_DUTY [5] = '{23, 88, 164, 221, 251};

  typedef struct {
    int half;
    int idx;
    int a_high;
    int b_high;
  } period_t;

  period_t exp_q[$];
  period_t mon_e;
  int      checks = 0;
  int      passed = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  spwm_sequencer_if bus0();
  spwm_sequencer_if bus1();

  assign bus1.en = bus0.en;

  spwm_sequencer #(.DEADTIME(DT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  spwm_sequencer #(.DEADTIME(0)) dut_dt0 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Reference: period k of a run sits at position k mod 10 of half (k/10) mod 2.
  function automatic void pushRun(input int total);
    period_t e;
    int      p;
    for (int k = 0; k < total; k++) begin
      p        = k % 10;
      e.half   = (k / 10) % 2;
      e.idx    = (p < 5) ? p : 9 - p;
      e.a_high = (e.half == 0) ? REF_DUTY[e.idx] - DT : 0;
      e.b_high = (e.half == 1) ? REF_DUTY[e.idx] - DT : 0;
      exp_q.push_back(e);
    end
  endfunction

  int a_cnt = 0, b_cnt = 0, overlap = 0;
  int prev_half = 0, prev_idx = 0;
  bit active = 1'b0;

  // Monitor: accumulate pulse counts per carrier period, score on each strobe.
  always @(negedge clk) begin
    if (bus0.period_strobe && active) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_period", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("period_half", prev_half, mon_e.half);
        checkOutput("period_idx", prev_idx, mon_e.idx);
        checkOutput("outa_high", a_cnt, mon_e.a_high);
        checkOutput("outb_high", b_cnt, mon_e.b_high);
        checkOutput("overlap", overlap, 0);
      end
      a_cnt = 0; b_cnt = 0; overlap = 0;
    end
    if (!bus0.busy || rst) begin
      active = 1'b0;
      a_cnt = 0; b_cnt = 0; overlap = 0;
    end else begin
      active = 1'b1;
      a_cnt += int'(bus0.outa);
      b_cnt += int'(bus0.outb);
      if (bus0.outa && bus0.outb) overlap++;
    end
    prev_half = int'(bus0.half);
    prev_idx  = int'(bus0.idx);
  end

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_outa"}, bus0.outa, 0);
    checkOutput({tag, "_outb"}, bus0.outb, 0);
    checkOutput({tag, "_busy"}, bus0.busy, 0);
    checkOutput({tag, "_half"}, bus0.half, 0);
    checkOutput({tag, "_idx"}, bus0.idx, 0);
    checkOutput({tag, "_strobe"}, bus0.period_strobe, 0);
    checkOutput({tag, "_dt0_outa"}, bus1.outa, 0);
  endtask

  // One run: start (by en or by releasing reset), drop en at n1, optionally
  // re-raise at m and drop again at n2, then wait for the half-boundary stop.
  task automatic applyStimulus(input bit via_reset, input int n1, input int m, input int n2);
    int nf, total, guard, a_first, a0_first, a0_high;
    nf    = (m >= 0) ? n2 : n1;
    total = ((nf + 1) / HALF_CLKS + 1) * 10;
    pushRun(total);
    a_first = -1; a0_first = -1; a0_high = 0;
    if (via_reset) rst = 1'b0;
    else           bus0.en = 1'b1;
    for (int c = 0; c <= nf; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checkOutput("start_busy", bus0.busy, 1);
        checkOutput("start_idx", bus0.idx, 0);
        checkOutput("start_half", bus0.half, 0);
      end
      if (c < PERIOD) begin
        if (bus0.outa && a_first < 0) a_first = c;
        if (bus1.outa) begin
          a0_high++;
          if (a0_first < 0) a0_first = c;
        end
      end
      if (c == PERIOD - 1) begin
        checkOutput("outa_first_high", a_first, DT + 1);
        checkOutput("dt0_outa_high", a0_high, REF_DUTY[0]);
        checkOutput("dt0_outa_first_high", a0_first, 1);
      end
      if (c == n1) bus0.en = 1'b0;
      if (m >= 0 && c == m) bus0.en = 1'b1;
      if (m >= 0 && c == n2) bus0.en = 1'b0;
    end
    guard = 0;
    while (bus0.busy && guard < 6000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("stop_timeout", bus0.busy, 0);
    checkOutput("idle_cycle", nf + guard, total * PERIOD);
    @(negedge clk);
    checkIdle("idle");
    checkOutput("queue_left", exp_q.size(), 0);
  endtask

  // Abort a run mid-period with reset; leaves reset asserted and en high.
  task automatic resetMidRun();
    bus0.en = 1'b1;
    pushRun(2);
    repeat (2 * PERIOD + 101) @(negedge clk);
    checkOutput("outa_mid_run", bus0.outa, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_outa", bus0.outa, 0);
    checkOutput("rst_outb", bus0.outb, 0);
    checkOutput("rst_busy", bus0.busy, 0);
    checkOutput("rst_idx", bus0.idx, 0);
    @(negedge clk);
    checkOutput("rst_queue_left", exp_q.size(), 0);
  endtask

  initial begin
    int n1, m, n2;
    bus0.en = 1'b0;
    rst     = 1'b1;
    repeat (3) @(negedge clk);
    checkIdle("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkIdle("post_reset");

    resetMidRun();
    n1 = int'($urandom_range(5120, 7678));
    applyStimulus(1'b1, n1, -1, -1);

    n1 = int'($urandom_range(767, 1022));
    applyStimulus(1'b0, n1, -1, -1);

    n1 = int'($urandom_range(300, 2000));
    m  = n1 + int'($urandom_range(1, 500));
    n2 = int'($urandom_range(2560, 5118));
    applyStimulus(1'b0, n1, m, n2);

    for (int r = 0; r < 2; r++) begin
      n1 = int'($urandom_range(300, 5118));
      applyStimulus(1'b0, n1, -1, -1);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
